// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// ADDSHARE_COUT_EN adds the carry-out field to rsp_t.
package adder_share_pkg;

  localparam int DATA_W   = 32;
  localparam int ID_MAX_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [ID_MAX_W-1:0] id;
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0]   sum;
    logic [ID_MAX_W-1:0] id;
`ifdef ADDSHARE_COUT_EN
    logic                cout;
`endif
  } rsp_t;

  // Carry out of the MSB recovered from the operand MSBs and the sum MSB.
  function automatic logic carry_msb(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin arbiter: search from ptr with wrap, one-hot grant gated by en,
// and the next pointer value (advances past the winner only on a transfer).
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic [IDW-1:0]  ptr_nxt
);

  int unsigned idx;
  logic        found;

  always_comb begin
    found   = 1'b0;
    idx     = 0;
    gnt_idx = '0;
    gnt     = '0;
    ptr_nxt = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    if (found && en) begin
      gnt[gnt_idx] = 1'b1;
      ptr_nxt      = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hybridadder32.sv
// 32-bit parallel-prefix (Kogge-Stone) adder, carry-in 0, sum only.
module hybridadder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] g [0:5];
  logic [31:0] p [0:4];

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Shifted-in zeros kill g, shifted-in ones let the low p bits pass through.
  for (genvar l = 0; l < 5; l++) begin : g_lvl
    assign g[l+1] = g[l] | (p[l] & (g[l] << (1 << l)));
    if (l < 4) begin : g_prop
      assign p[l+1] = p[l] & ((p[l] << (1 << l)) | ~(32'hFFFF_FFFF << (1 << l)));
    end
  end

  assign sum = p[0] ^ {g[5][30:0], 1'b0};

endmodule

// File: rtl/adder_share_arb.sv
// Shares one hybridadder32 among NREQ requesters via a two-stage pipeline.
// Define ADDSHARE_COUT_EN to add the registered rsp_cout output.
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic [IDW-1:0]         rsp_id,
`ifdef ADDSHARE_COUT_EN
  output logic                   rsp_cout,
`endif
  output logic                   busy
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [IDW-1:0]    s1_id;
  logic [IDW-1:0]    ptr, ptr_nxt, gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic              s2_load, s1_open, xfer;
  logic [DATA_W-1:0] sel_a, sel_b, add_sum;

  assign s2_load   = s1_valid && (!rsp_valid || rsp_ready);
  assign s1_open   = !s1_valid || s2_load;
  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign busy      = s1_valid | rsp_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (s1_open),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr_nxt (ptr_nxt)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  hybridadder32 u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= gnt_idx;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
`ifdef ADDSHARE_COUT_EN
      rsp_cout  <= 1'b0;
`endif
    end else if (s2_load) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum;
      rsp_id    <= s1_id;
`ifdef ADDSHARE_COUT_EN
      rsp_cout  <= carry_msb(s1_a[DATA_W-1], s1_b[DATA_W-1], add_sum[DATA_W-1]);
`endif
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb against a queue-based reference
// model: at most two operations in flight, each visible two cycles after issue.
module tb_adder_share_arb;

  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid, req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_sum;
  logic [1:0]       rsp_id;
  logic             busy;
`ifdef ADDSHARE_COUT_EN
  logic             rsp_cout;
`endif

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
`ifdef ADDSHARE_COUT_EN
    .rsp_cout  (rsp_cout),
`endif
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] sum;
    int          id;
    bit          cout;
    int          age;
  } ent_t;

  ent_t        q[$];
  int          m_ptr;
  logic [3:0]  acc_last;

  function automatic int m_grant();
    int idx;
    for (int i = 0; i < NREQ; i++) begin
      idx = (m_ptr + i) % NREQ;
      if (req_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_rsp_valid();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  function automatic bit m_can_acc();
    return (q.size() < 2) || (m_rsp_valid() && (rsp_ready === 1'b1));
  endfunction

  // {req_ready[4], rsp_valid, busy, sum[32], id[2], cout}
  function automatic logic [40:0] m_exp();
    logic [3:0]  rr;
    logic [31:0] s;
    logic [1:0]  id;
    logic        c;
    int          g;
    g  = m_grant();
    rr = (g >= 0 && m_can_acc()) ? 4'(1 << g) : 4'b0;
    s  = '0;
    id = '0;
    c  = 1'b0;
    if (m_rsp_valid()) begin
      s  = q[0].sum;
      id = 2'(q[0].id);
`ifdef ADDSHARE_COUT_EN
      c  = q[0].cout;
`endif
    end
    return {rr, m_rsp_valid(), (q.size() > 0), s, id, c};
  endfunction

  function automatic logic [40:0] observe(input logic mask);
    logic c;
    c = 1'b0;
`ifdef ADDSHARE_COUT_EN
    c = rsp_cout;
`endif
    return {req_ready, rsp_valid, busy, mask ? rsp_sum : 32'h0,
            mask ? rsp_id : 2'h0, mask ? c : 1'b0};
  endfunction

  task automatic model_edge();
    int         g;
    bit         acc;
    logic [32:0] full;
    g   = m_grant();
    acc = (g >= 0) && m_can_acc();
    if (m_rsp_valid() && rsp_ready === 1'b1) void'(q.pop_front());
    foreach (q[j]) q[j].age = q[j].age + 1;
    acc_last = '0;
    if (acc) begin
      full = 33'(req_a[g*32 +: 32]) + 33'(req_b[g*32 +: 32]);
      q.push_back('{full[31:0], g, full[32], 1});
      m_ptr       = (g + 1) % NREQ;
      acc_last[g] = 1'b1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr    = 0;
    acc_last = '0;
  endtask

  // Requesters keep valid and operands stable until accepted.
  task automatic refresh(input int pct, input logic [3:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || acc_last[i]) begin
        req_valid[i] = mask[i] && ($urandom_range(99) < pct);
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic c;
    repeat (2) @(negedge clk);
    c = 1'b0;
`ifdef ADDSHARE_COUT_EN
    c = rsp_cout;
`endif
    vecs++;
    if ({req_ready, rsp_valid, busy} !== 6'b0) begin
      miss++;
      $display("FAIL reset_ctrl got=%b exp=000000", {req_ready, rsp_valid, busy});
    end
    vecs++;
    if ({rsp_sum, rsp_id, c} !== 35'h0) begin
      miss++;
      $display("FAIL reset_data got=%h exp=0", {rsp_sum, rsp_id, c});
    end
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_single();
    logic [40:0] e, o;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h5;
    req_b[64 +: 32] = 32'h7;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc == 2) begin
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 32'hC || rsp_id !== 2'd2) begin
          miss++;
          $display("FAIL single_result valid=%b sum=%h id=%0d exp 1/0000000c/2", rsp_valid, rsp_sum, rsp_id);
        end
      end
      @(posedge clk); model_edge(); #1;
      refresh(0, 4'hF);
    end
  endtask

  task automatic test_contend();
    logic [40:0] e, o;
    do_reset();
    rsp_ready = 1'b1;
    refresh(100, 4'hF);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL contend cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc >= 2) begin
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(cyc - 2)) begin
          miss++;
          $display("FAIL contend_order cyc=%0d valid=%b id=%0d exp 1/%0d", cyc, rsp_valid, rsp_id, (cyc - 2) % 4);
        end
      end
      @(posedge clk); model_edge(); #1;
      refresh(100, 4'hF);
    end
    req_valid = '0;
    repeat (3) begin
      @(posedge clk); model_edge(); #1;
    end
  endtask

  task automatic test_wrap();
    logic [40:0] e, o;
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    req_a[0 +: 32]  = 32'hFFFF_FFFF; req_b[0 +: 32]  = 32'h1;
    req_a[32 +: 32] = 32'h7FFF_FFFF; req_b[32 +: 32] = 32'h1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (rsp_valid === 1'b1) begin
        vecs++;
        if (rsp_sum !== (rsp_id == 2'd0 ? 32'h0 : 32'h8000_0000)) begin
          miss++;
          $display("FAIL wrap_sum id=%0d got=%h", rsp_id, rsp_sum);
        end
`ifdef ADDSHARE_COUT_EN
        vecs++;
        if (rsp_cout !== (rsp_id == 2'd0)) begin
          miss++;
          $display("FAIL wrap_cout id=%0d got=%b", rsp_id, rsp_cout);
        end
`endif
      end
      @(posedge clk); model_edge(); #1;
      refresh(0, 4'hF);
    end
  endtask

  task automatic test_backpressure();
    logic [40:0] e, o;
    int acc_cnt;
    acc_cnt   = 0;
    rsp_ready = 1'b0;
    refresh(100, 4'b0011);
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 5) rsp_ready = 1'b1;
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc < 5 && |(req_valid & req_ready)) acc_cnt++;
      if (cyc == 4) begin
        vecs++;
        if (acc_cnt !== 2 || req_ready !== 4'b0) begin
          miss++;
          $display("FAIL bp_accepts got=%0d ready=%b exp=2 ready=0000", acc_cnt, req_ready);
        end
      end
      @(posedge clk); model_edge(); #1;
      if (cyc < 4) refresh(100, 4'b0011);
      else         refresh(0, 4'hF);
    end
  endtask

  task automatic test_fairness();
    logic [40:0] e, o;
    logic [3:0]  want;
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    req_a[96 +: 32] = $urandom; req_b[96 +: 32] = $urandom;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL fairness cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc < 3) begin
        want = (cyc == 1) ? 4'b0001 : 4'b1000;
        vecs++;
        if (req_ready !== want) begin
          miss++;
          $display("FAIL fairness_grant cyc=%0d got=%b exp=%b", cyc, req_ready, want);
        end
      end
      @(posedge clk); model_edge(); #1;
      if (cyc == 0) begin
        req_valid = 4'b1001;
        req_a[0 +: 32]  = $urandom; req_b[0 +: 32]  = $urandom;
        req_a[96 +: 32] = $urandom; req_b[96 +: 32] = $urandom;
      end else begin
        refresh(0, 4'hF);
      end
    end
  endtask

  task automatic test_random();
    logic [40:0] e, o;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rsp_ready = ($urandom_range(99) < 70);
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      @(posedge clk); model_edge(); #1;
      refresh(60, 4'hF);
    end
  endtask

  task automatic test_reset_mid();
    logic [40:0] e, o;
    rsp_ready = 1'b0;
    refresh(100, 4'hF);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL reset_mid_fill cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      if (cyc < 2) begin
        @(posedge clk); model_edge(); #1;
        refresh(100, 4'hF);
      end
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miss++;
      $display("FAIL reset_mid_clear valid=%b busy=%b exp 0/0", rsp_valid, busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++;
    if (req_ready !== 4'b0010) begin
      miss++;
      $display("FAIL reset_mid_first_grant got=%b exp=0010", req_ready);
    end
    @(posedge clk); model_edge(); #1;
    refresh(0, 4'hF);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      e = m_exp(); o = observe(e[36]);
      vecs++;
      if (o !== e) begin
        miss++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, o, e);
      end
      @(posedge clk); model_edge(); #1;
      refresh(0, 4'hF);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_contend();
    test_wrap();
    test_backpressure();
    test_fairness();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
